fetch_stage: RTL and testbench

Instruction fetch stage for the 32-bit pipelined core: holds the PC, issues word reads to instruction memory over a req/ack handshake, and presents each fetched instruction with its PC to decode, where the opcode field [31:28] is decoded and the immediate generator extracts immediates. It includes a one-entry skid buffer so memory responses are never lost when decode stalls. Taken branches from execute redirect fetch and squash wrong-path instructions, including a memory read already in flight.

---
 rtl/fetch_stage.sv | 103 ++++++++++
 tb/tb_fetch_stage.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem req/ack handshake, IF/ID register and one-entry skid buffer.
// Ack in cycle N shows at decode in N+1; under stall the out register holds, one extra word parks in skid, then issue pauses.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid
);

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] redirect_pc;
  logic [31:0] skid_data;
  logic [31:0] skid_pc;
  logic        skid_valid;
  logic        outstanding;
  logic        active;
  logic        ack_acc;
  logic        fill;
  logic        load_en;

  // active keeps the request low for the first cycle after reset releases
  assign imem_req  = active && (state == DRAIN || outstanding || !skid_valid);
  assign imem_addr = pc;
  assign ack_acc   = imem_req && imem_ack;
  assign fill      = ack_acc && (state == FETCH);
  assign load_en   = !instr_valid || !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      redirect_pc <= 32'd0;
      skid_data   <= 32'd0;
      skid_pc     <= 32'd0;
      skid_valid  <= 1'b0;
      outstanding <= 1'b0;
      active      <= 1'b0;
      instr       <= 32'd0;
      instr_pc    <= 32'd0;
      instr_valid <= 1'b0;
    end else begin
      active      <= 1'b1;
      outstanding <= imem_req && !imem_ack;
      if (branch_taken) begin
        instr_valid <= 1'b0;
        skid_valid  <= 1'b0;
        // an unacked request must keep its address, so park the target until the ack drains
        if (imem_req && !imem_ack) begin
          redirect_pc <= branch_target;
          state       <= DRAIN;
        end else begin
          pc    <= branch_target;
          state <= FETCH;
        end
      end else begin
        if (state == DRAIN) begin
          if (ack_acc) begin
            pc    <= redirect_pc;
            state <= FETCH;
          end
        end else if (ack_acc) begin
          pc <= pc + 32'd1;
        end

        if (load_en) begin
          if (skid_valid) begin
            instr       <= skid_data;
            instr_pc    <= skid_pc;
            instr_valid <= 1'b1;
            skid_valid  <= 1'b0;
          end else if (fill) begin
            instr       <= imem_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
          end else begin
            instr_valid <= 1'b0;
          end
        end

        // requests only issue with skid empty, so a fill that misses the out register always fits here
        if (fill && !(load_en && !skid_valid)) begin
          skid_data  <= imem_data;
          skid_pc    <= pc;
          skid_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run against a program-order model.
module tb_fetch_stage;

  localparam logic [31:0] RP = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        spur = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;

  int n_cmp = 0;
  int n_bad = 0;
  int fixed_wait = 0;
  bit rand_wait = 1'b0;
  int wcnt = 0;
  int cur_wait = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RP)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // memory: ack after cur_wait wait states; spur forces an ack with no request
  assign imem_ack  = (imem_req && (wcnt >= cur_wait)) || spur;
  assign imem_data = mem_word(imem_addr);

  always @(posedge clk) begin
    if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else begin
      wcnt     <= 0;
      cur_wait <= rand_wait ? int'($urandom_range(0, 3)) : fixed_wait;
    end
  end

  // an unacked request must hold its address into the next cycle
  logic        hold_q = 1'b0;
  logic [31:0] addr_q = 32'd0;
  always @(negedge clk) begin
    if (hold_q && !rst) begin
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== addr_q) begin
        n_bad++;
        $display("FAIL req_hold: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, addr_q);
      end
    end
    hold_q <= imem_req && !imem_ack;
    addr_q <= imem_addr;
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; spur = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    cyc(); cyc();
    n_cmp++;
    if ({imem_req, imem_addr, instr, instr_pc, instr_valid} !== {1'b0, RP, 32'd0, 32'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_vals: req=%b addr=%h instr=%h pc=%h v=%b, required 0 %h 0 0 0",
               imem_req, imem_addr, instr, instr_pc, instr_valid, RP);
    end
    rst = 1'b0;
    cyc();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== RP || instr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL first_req: req=%b addr=%h v=%b, required 1 %h 0", imem_req, imem_addr, instr_valid, RP);
    end
    cyc();
    n_cmp++;
    if (instr_valid !== 1'b1 || instr_pc !== RP || instr !== mem_word(RP)) begin
      n_bad++;
      $display("FAIL first_instr: v=%b pc=%h instr=%h, required 1 %h %h", instr_valid, instr_pc, instr, RP, mem_word(RP));
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] e;
    fixed_wait = 0;
    pulse_reset();
    for (int k = 0; k < 8; k++) begin
      cyc();
      e = RP + 32'(k);
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== e) begin
        n_bad++;
        $display("FAIL zw_addr k=%0d: req=%b addr=%h, required 1 %h", k, imem_req, imem_addr, e);
      end
      if (k > 0) begin
        n_cmp++;
        if (instr_valid !== 1'b1 || instr_pc !== e - 32'd1 || instr !== mem_word(e - 32'd1)) begin
          n_bad++;
          $display("FAIL zw_instr k=%0d: v=%b pc=%h, required 1 %h", k, instr_valid, instr_pc, e - 32'd1);
        end
      end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] e;
    logic        ev;
    fixed_wait = 3;
    pulse_reset();
    for (int c = 0; c < 20; c++) begin
      cyc();
      e  = RP + 32'(c / 4);
      ev = (c >= 4) && (c % 4 == 0);
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== e || instr_valid !== ev) begin
        n_bad++;
        $display("FAIL ws c=%0d: req=%b addr=%h v=%b, required 1 %h %b", c, imem_req, imem_addr, instr_valid, e, ev);
      end
      if (ev) begin
        n_cmp++;
        if (instr_pc !== e - 32'd1 || instr !== mem_word(e - 32'd1)) begin
          n_bad++;
          $display("FAIL ws_pc c=%0d: pc=%h, required %h", c, instr_pc, e - 32'd1);
        end
      end
    end
    fixed_wait = 0;
  endtask

  task automatic test_stall();
    fixed_wait = 0;
    pulse_reset();
    cyc(); cyc(); cyc();
    stall = 1'b1;
    for (int c = 3; c < 7; c++) begin
      cyc();
      n_cmp++;
      if (instr_valid !== 1'b1 || instr_pc !== RP + 32'd1 || imem_req !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold c=%0d: v=%b pc=%h req=%b, required 1 %h 0", c, instr_valid, instr_pc, imem_req, RP + 32'd1);
      end
    end
    stall = 1'b0;
    for (int c = 7; c < 10; c++) begin
      cyc();
      n_cmp++;
      if (instr_valid !== 1'b1 || instr_pc !== RP + 32'(c - 5) || instr !== mem_word(RP + 32'(c - 5))) begin
        n_bad++;
        $display("FAIL stall_release c=%0d: v=%b pc=%h, required 1 %h", c, instr_valid, instr_pc, RP + 32'(c - 5));
      end
    end
  endtask

  task automatic test_branch_ack();
    fixed_wait = 0;
    pulse_reset();
    cyc(); cyc(); cyc(); cyc();
    n_cmp++;
    if (imem_addr !== RP + 32'd3 || imem_ack !== 1'b1) begin
      n_bad++;
      $display("FAIL br_setup: addr=%h ack=%b, required %h 1", imem_addr, imem_ack, RP + 32'd3);
    end
    branch_taken = 1'b1; branch_target = 32'h40;
    cyc();
    branch_taken = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40 || instr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL br_redirect: req=%b addr=%h v=%b, required 1 00000040 0", imem_req, imem_addr, instr_valid);
    end
    cyc();
    n_cmp++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== mem_word(32'h40) || imem_addr !== 32'h41) begin
      n_bad++;
      $display("FAIL br_target: v=%b pc=%h addr=%h, required 1 00000040 00000041", instr_valid, instr_pc, imem_addr);
    end
  endtask

  task automatic test_branch_drain();
    fixed_wait = 2;
    pulse_reset();
    cyc(); cyc(); cyc(); cyc();
    n_cmp++;
    if (instr_valid !== 1'b1 || instr_pc !== RP || imem_addr !== RP + 32'd1 || imem_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_setup: v=%b pc=%h addr=%h ack=%b", instr_valid, instr_pc, imem_addr, imem_ack);
    end
    branch_taken = 1'b1; branch_target = 32'h200;
    for (int c = 4; c < 9; c++) begin
      cyc();
      branch_taken = 1'b0;
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== ((c < 6) ? RP + 32'd1 : 32'h200) || instr_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL drain c=%0d: req=%b addr=%h v=%b, required 1 %h 0", c, imem_req, imem_addr, instr_valid,
                 (c < 6) ? RP + 32'd1 : 32'h200);
      end
    end
    cyc();
    n_cmp++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || instr !== mem_word(32'h200)) begin
      n_bad++;
      $display("FAIL drain_target: v=%b pc=%h, required 1 00000200", instr_valid, instr_pc);
    end
    fixed_wait = 0;
  endtask

  task automatic test_reset_mid();
    fixed_wait = 3;
    pulse_reset();
    stall = 1'b1;
    for (int c = 0; c < 6; c++) cyc();
    n_cmp++;
    if (instr_valid !== 1'b1 || instr_pc !== RP || imem_req !== 1'b1 || imem_addr !== RP + 32'd1 || imem_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_setup: v=%b pc=%h req=%b addr=%h ack=%b", instr_valid, instr_pc, imem_req, imem_addr, imem_ack);
    end
    rst = 1'b1; spur = 1'b1;
    for (int c = 6; c < 8; c++) begin
      cyc();
      n_cmp++;
      if ({imem_req, imem_addr, instr, instr_pc, instr_valid} !== {1'b0, RP, 32'd0, 32'd0, 1'b0}) begin
        n_bad++;
        $display("FAIL rmid_reset c=%0d: req=%b addr=%h instr=%h pc=%h v=%b", c, imem_req, imem_addr, instr, instr_pc, instr_valid);
      end
    end
    rst = 1'b0; spur = 1'b0; stall = 1'b0;
    for (int c = 8; c < 13; c++) begin
      cyc();
      n_cmp++;
      if (imem_addr !== ((c < 12) ? RP : RP + 32'd1) || instr_valid !== (c == 12) ||
          (c == 12 && instr_pc !== RP)) begin
        n_bad++;
        $display("FAIL rmid_restart c=%0d: addr=%h v=%b pc=%h", c, imem_addr, instr_valid, instr_pc);
      end
    end
    fixed_wait = 0;
  endtask

  // decode must see target, target+1, ... after each redirect, with squashed words never appearing
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    logic        st;
    logic        br;
    logic        exp_invalid;
    int          consumed;
    rand_wait = 1'b1;
    pulse_reset();
    exp_pc = RP; exp_invalid = 1'b0; consumed = 0;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if (exp_invalid) begin
        n_cmp++;
        if (instr_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL rnd_squash i=%0d: v=%b, required 0", i, instr_valid);
        end
      end
      st  = ($urandom_range(0, 9) < 3);
      br  = ($urandom_range(0, 19) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : $urandom;
      stall = st; branch_taken = br; branch_target = tgt;
      if (instr_valid === 1'b1 && !st && !br) begin
        n_cmp++;
        if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
          n_bad++;
          $display("FAIL rnd_order i=%0d: pc=%h instr=%h, required %h %h", i, instr_pc, instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd1;
        consumed++;
      end
      if (br) exp_pc = tgt;
      exp_invalid = br;
    end
    stall = 1'b0; branch_taken = 1'b0; rand_wait = 1'b0;
    n_cmp++;
    if (consumed <= 300) begin
      n_bad++;
      $display("FAIL rnd_progress: consumed=%0d, required >300", consumed);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_branch_ack();
    test_branch_drain();
    test_reset_mid();
    test_random();
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
